// File: rtl/wave_sequencer_pkg.sv
// rtl/wave_sequencer_pkg.sv - shared definitions for the waveform sequencer
// Contents: FSM state encoding, program-entry field offsets, pi reset value.
// Entry layout (LSB first): sel[2:0], amp[1:0], pi[8:0], dwell[DWELL_W-1:0].
package wave_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_NEXT
    } state_e;

    localparam int SEL_LSB   = 0;
    localparam int AMP_LSB   = 3;
    localparam int PI_LSB    = 5;
    localparam int DWELL_LSB = 14;

    localparam logic [8:0] PI_RESET = 9'h1FC;

endpackage

// File: rtl/wave_seq_mem.sv
// rtl/wave_seq_mem.sv - program table, synchronous write, 1-cycle synchronous read
// Ports:
//   clk_i            clock
//   we_i/waddr_i     write strobe / address
//   wdata_i          write data (one program entry)
//   raddr_i          read address, captured every cycle
//   rdata_o          entry at raddr_i from the previous edge
// Contents are deliberately not reset.
module wave_seq_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 30
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - program-table scheduler for the waveform generator chain
// Optional feature macro: WAVE_SEQ_PAUSE_EN (adds pause input that freezes the dwell count).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, stop         begin program at entry 0 / abort (stop wins)
//   loop_en             wrap to entry 0 after the last entry
//   prog_len            valid entries, latched on start, clamped to DEPTH
//   wr_en/wr_addr/wr_data  program table write port
//   pause               (WAVE_SEQ_PAUSE_EN only) hold dwell count in PLAY
//   sel, amp_sel, pi    generator settings, held between programs
//   init                frequency-selector load strobe
//   busy, done          program running / one-cycle normal-end pulse
//   step_idx            entry currently playing
module wave_sequencer
    import wave_sequencer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int DWELL_W     = 16,
    parameter int INIT_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [AW:0]         prog_len,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DWELL_W+13:0] wr_data,
`ifdef WAVE_SEQ_PAUSE_EN
    input  logic                pause,
`endif
    output logic [2:0]          sel,
    output logic [1:0]          amp_sel,
    output logic [8:0]          pi,
    output logic                init,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       step_idx
);

    localparam int IW = $clog2(INIT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW:0]          len_q, len_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]        init_cnt_q, init_cnt_d;
    logic [2:0]           sel_q, sel_d;
    logic [1:0]           amp_q, amp_d;
    logic [8:0]           pi_q, pi_d;
    logic                 first_q, first_d;
    logic                 done_q, done_d;
    logic                 hold_cnt;

    logic [DWELL_W+13:0]  rdata;
    logic [2:0]           e_sel;
    logic [1:0]           e_amp;
    logic [8:0]           e_pi;
    logic [DWELL_W-1:0]   e_dwell;

    wave_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (DWELL_W + 14)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_q),
        .rdata_o (rdata)
    );

    assign e_sel   = rdata[SEL_LSB +: 3];
    assign e_amp   = rdata[AMP_LSB +: 2];
    assign e_pi    = rdata[PI_LSB +: 9];
    assign e_dwell = rdata[DWELL_LSB +: DWELL_W];

`ifdef WAVE_SEQ_PAUSE_EN
    assign hold_cnt = pause;
`else
    assign hold_cnt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        amp_d      = amp_q;
        pi_d       = pi_q;
        first_d    = first_q;
        done_d     = 1'b0;
        // The init pulse free-runs down to zero; it is only cut short by the
        // next entry's LOAD or by stop, so it may finish after a normal end.
        init_cnt_d = (init_cnt_q != '0) ? init_cnt_q - 1'b1 : '0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (prog_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        idx_d   = '0;
                        first_d = 1'b1;
                        len_d   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sel_d   = e_sel;
                amp_d   = e_amp;
                pi_d    = e_pi;
                cnt_d   = (e_dwell == '0) ? DWELL_W'(1) : e_dwell;
                first_d = 1'b0;
                if (first_q || (e_pi != pi_q)) begin
                    init_cnt_d = IW'(INIT_CYCLES);
                end else begin
                    init_cnt_d = '0;
                end
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!hold_cnt) begin
                    if (cnt_q == DWELL_W'(1)) begin
                        state_d = ST_NEXT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if ({1'b0, idx_q} == len_q - 1'b1) begin
                    if (loop_en) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            init_cnt_d = '0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            init_cnt_q <= '0;
            sel_q      <= '0;
            amp_q      <= '0;
            pi_q       <= PI_RESET;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            init_cnt_q <= init_cnt_d;
            sel_q      <= sel_d;
            amp_q      <= amp_d;
            pi_q       <= pi_d;
            first_q    <= first_d;
            done_q     <= done_d;
        end
    end

    assign sel      = sel_q;
    assign amp_sel  = amp_q;
    assign pi       = pi_q;
    assign init     = (init_cnt_q != '0);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign step_idx = idx_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// tb/tb_wave_sequencer.sv - self-checking bench for wave_sequencer
module tb_wave_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;

    logic              clk = 1'b0;
    logic              rst, start, stop, loop_en, wr_en;
    logic [AW:0]       prog_len;
    logic [AW-1:0]     wr_addr;
    logic [DW+13:0]    wr_data;
`ifdef WAVE_SEQ_PAUSE_EN
    logic              pause;
`endif
    logic [2:0]        sel;
    logic [1:0]        amp_sel;
    logic [8:0]        pi;
    logic              init, busy, done;
    logic [AW-1:0]     step_idx;
    logic [19:0]       obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    wave_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .DWELL_W(DW), .INIT_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .prog_len(prog_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef WAVE_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .sel(sel), .amp_sel(amp_sel), .pi(pi), .init(init), .busy(busy),
        .done(done), .step_idx(step_idx)
    );

    assign obs = {sel, amp_sel, pi, init, busy, done, step_idx};

    // {sel, amp, pi, init, busy, done, idx}
    function automatic logic [19:0] ex(int s, int a, int p, bit i, bit b, bit d, int x);
        return {3'(s), 2'(a), 9'(p), i, b, d, 3'(x)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int dwell, input int p, input int a, input int s);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {16'(dwell), 9'(p), 2'(a), 3'(s)};
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_prog3();
        write_entry(0, 4, 'h1FC, 0, 0);
        write_entry(1, 2, 'h1FC, 1, 1);
        write_entry(2, 3, 'h1FD, 3, 2);
    endtask

    task automatic run_to(input int k_end);
        // start is applied at edge 0; returns just after edge k_end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= k_end; k++) tick();
    endtask

    initial begin : main
        int k_done;
        logic done_seen;

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
        prog_len = 4'd3; wr_addr = '0; wr_data = '0;
`ifdef WAVE_SEQ_PAUSE_EN
        pause = 1'b0;
`endif

        // Reset state
        repeat (5) tick();
        check("reset", obs, ex(0, 0, 'h1FC, 0, 0, 0, 0));
        rst = 1'b0;
        tick();

        // Three-step program, no loop: cycle-exact table
        load_prog3();
        vecs[0]  = '{1'b1, ex(0, 0, 'h1FC, 0, 1, 0, 0)};
        vecs[1]  = '{1'b0, ex(0, 0, 'h1FC, 0, 1, 0, 0)};
        for (int k = 2; k <= 6; k++) vecs[k] = '{1'b0, ex(0, 0, 'h1FC, 1, 1, 0, 0)};
        vecs[7]  = '{1'b0, ex(0, 0, 'h1FC, 0, 1, 0, 1)};
        vecs[8]  = '{1'b0, ex(0, 0, 'h1FC, 0, 1, 0, 1)};
        for (int k = 9; k <= 11; k++) vecs[k] = '{1'b0, ex(1, 1, 'h1FC, 0, 1, 0, 1)};
        vecs[12] = '{1'b0, ex(1, 1, 'h1FC, 0, 1, 0, 2)};
        vecs[13] = '{1'b0, ex(1, 1, 'h1FC, 0, 1, 0, 2)};
        for (int k = 14; k <= 17; k++) vecs[k] = '{1'b0, ex(2, 3, 'h1FD, 1, 1, 0, 2)};
        vecs[18] = '{1'b0, ex(2, 3, 'h1FD, 1, 0, 1, 2)};
        vecs[19] = '{1'b0, ex(2, 3, 'h1FD, 0, 0, 0, 2)};
        for (int k = 0; k < 20; k++) begin
            start = vecs[k].start;
            tick();
            check($sformatf("prog3 vec%0d", k), obs, vecs[k].exp);
        end
        start = 1'b0;

        // Looping: step 0 follows step 2 with a fresh init, done never pulses
        loop_en = 1'b1;
        done_seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (done) done_seen = 1'b1;
            if (k == 18) check("loop wrap fetch", obs, ex(2, 3, 'h1FD, 1, 1, 0, 0));
            if (k == 20) check("loop reentry init", obs, ex(0, 0, 'h1FC, 1, 1, 0, 0));
            if (k == 27) check("loop step1 again", obs, ex(1, 1, 'h1FC, 0, 1, 0, 1));
        end
        check("loop no done", 32'(done_seen), 32'd0);
        loop_en = 1'b0;

        // Stop during step 1 PLAY
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop step1", obs, ex(1, 1, 'h1FC, 0, 0, 0, 1));

        // Stop during step 2 while init is high
        run_to(15);
        check("pre-stop step2", obs, ex(2, 3, 'h1FD, 1, 1, 0, 2));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop step2", obs, ex(2, 3, 'h1FD, 0, 0, 0, 2));
        tick();
        check("stop no done", obs, ex(2, 3, 'h1FD, 0, 0, 0, 2));

        // start and stop together: stay idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start+stop", obs, ex(2, 3, 'h1FD, 0, 0, 0, 2));
        tick();
        check("start+stop after", obs, ex(2, 3, 'h1FD, 0, 0, 0, 2));

        // prog_len = 0: single done pulse, never busy
        prog_len = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len0 done", obs, ex(2, 3, 'h1FD, 0, 0, 1, 2));
        tick();
        check("len0 after", obs, ex(2, 3, 'h1FD, 0, 0, 0, 2));

        // rst mid-program
        prog_len = 4'd3;
        run_to(15);
        rst = 1'b1;
        tick();
        check("mid rst", obs, ex(0, 0, 'h1FC, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        check("mid rst idle", obs, ex(0, 0, 'h1FC, 0, 0, 0, 0));

        // dwell=0 plays one cycle; init truncated by the next LOAD
        write_entry(0, 0, 'h0AB, 2, 5);
        write_entry(1, 1, 'h0AB, 0, 6);
        prog_len = 4'd2;
        run_to(2);
        check("dw0 load", obs, ex(5, 2, 'h0AB, 1, 1, 0, 0));
        for (int k = 3; k <= 5; k++) tick();
        check("dw0 end step0", obs, ex(5, 2, 'h0AB, 1, 1, 0, 1));
        tick();
        check("dw0 step1", obs, ex(6, 0, 'h0AB, 0, 1, 0, 1));
        tick(); tick();
        check("dw0 done", obs, ex(6, 0, 'h0AB, 0, 0, 1, 1));

        // prog_len above DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) write_entry(i, 1, 'h0AB, 0, i);
        prog_len = 4'd9;
        k_done = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 60; k++) begin
            tick();
            if (done) begin
                k_done = k;
                break;
            end
        end
        check("clamp done edge", 32'(k_done), 32'd32);
        check("clamp end state", obs, ex(7, 0, 'h0AB, 0, 0, 1, 7));

`ifdef WAVE_SEQ_PAUSE_EN
        // pause for 10 cycles in step 0 lengthens it by exactly 10
        load_prog3();
        prog_len = 4'd3;
        k_done = -1;
        run_to(4);
        pause = 1'b1;
        for (int k = 5; k <= 14; k++) tick();
        pause = 1'b0;
        for (int k = 15; k < 40; k++) begin
            tick();
            if (sel == 3'd1) begin
                k_done = k;
                break;
            end
        end
        check("pause step1 edge", 32'(k_done), 32'd19);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
